// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder: accepts one request, waits LATENCY
// cycles, performs the masked write or read, then holds the response until taken.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DATA_W = 32;
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_CNT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   logic              wen_p0;
   logic [29:0]       widx_p0;
   logic [DATA_W-1:0] wdata_p0;
   logic [3:0]        wmask_p0;

   logic              accept;
   logic              enter_resp;
   logic              in_range_p0;
   logic [AW-1:0]     idx_p0;
   logic [DATA_W-1:0] mem_rd;
   logic              mem_we;
   logic              addr_lsb_unused;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [3:0]        mask);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   // Byte offset within the word is the initiator's concern
   assign addr_lsb_unused = ^req_addr[1:0];

   assign accept      = (state == IDLE) && req_valid && req_ready;
   assign enter_resp  = (state == WAIT) && (cnt == 4'd0);
   assign idx_p0      = widx_p0[AW-1:0];
   assign in_range_p0 = ~|widx_p0[29:AW];
   assign mem_rd      = mem[idx_p0];
   assign mem_we      = enter_resp && wen_p0 && in_range_p0;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = WAIT;
               cnt_nxt   = LAT_CNT;
            end
         end
         WAIT: begin
            // A zero count still spends one cycle here, so rsp_valid lands LATENCY+1 edges after accept
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Control and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= (state_nxt == IDLE);
         rsp_valid <= (state_nxt == RESP);
         if (enter_resp) begin
            rsp_rdata <= (!wen_p0 && in_range_p0) ? mem_rd : '0;
            rsp_err   <= !in_range_p0;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
         end
      end
   end

   // Request capture
   always_ff @(posedge clk) begin
      if (accept) begin
         wen_p0   <= req_wen;
         widx_p0  <= req_addr[31:2];
         wdata_p0 <= req_wdata;
         wmask_p0 <= req_wmask;
      end
   end

   // Storage, never reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx_p0] <= merge_bytes(mem_rd, wdata_p0, wmask_p0);
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=0.
module tb_data_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_wen   [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wmask [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int total;
   int passed;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      else
         passed++;
   endtask

   // One complete transaction; returns the response and the edge count from accept to rsp_valid
   task automatic txn(input int d, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      output logic [31:0] rd, output logic err, output int lat);
      bit got;
      rd  = '0;
      err = 1'b0;
      lat = -1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready[d] === 1'b1) got = 1'b1;
      end
      if (!got) begin
         chk("req_ready_timeout", 32'(req_ready[d]), 32'd1);
         return;
      end
      req_valid[d] = 1'b1;
      req_wen[d]   = wen;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_wmask[d] = mask;
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid[d] === 1'b1) begin
            got = 1'b1;
            lat = i;
         end
      end
      if (!got) begin
         chk("rsp_valid_timeout", 32'(rsp_valid[d]), 32'd1);
         return;
      end
      rd  = rsp_rdata[d];
      err = rsp_err[d];
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[d] = 1'b0;
   endtask

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] rd;
      logic        err;
      int          lat;
      bit          seen;

      total  = 0;
      passed = 0;
      rst_n  = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_wen[d]   = 1'b0;
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         req_wmask[d] = '0;
         rsp_ready[d] = 1'b0;
      end

      vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0023, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, 4'hF, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1});
      vecs.push_back('{1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1});
      vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1});
      vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h0BAD_CAFE, 1'b0});
      vecs.push_back('{1'b1, 32'h0000_0010, 32'h0000_FF00, 4'h2, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_FFEF, 1'b0});

      // Reset state
      #12;
      chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_req_ready0", 32'(req_ready[0]), 32'd1);
      chk("post_rst_req_ready1", 32'(req_ready[1]), 32'd1);

      // Table-driven transactions on the LATENCY=2 instance
      foreach (vecs[i]) begin
         txn(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd, err, lat);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      end
      // Restore word 4 to its original value for later checks
      txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, err, lat);

      // Response back-pressure with spurious request activity
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_wen[0]   = 1'b0;
      req_addr[0]  = 32'h10;
      @(posedge clk);
      #1;
      req_wen[0]   = 1'b1;
      req_wdata[0] = 32'h0;
      req_wmask[0] = 4'hF;
      chk("wait_rdata_zero", rsp_rdata[0], 32'd0);
      chk("wait_req_ready", 32'(req_ready[0]), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (rsp_valid[0] === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("stall_rsp_seen", 32'(seen), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_valid", i), 32'(rsp_valid[0]), 32'd1);
         chk($sformatf("stall%0d_rdata", i), rsp_rdata[0], 32'hDEAD_BEEF);
         chk($sformatf("stall%0d_req_ready", i), 32'(req_ready[0]), 32'd0);
         @(posedge clk);
         #1;
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[0] = 1'b0;
      req_valid[0] = 1'b0;
      chk("hs_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("hs_rsp_rdata", rsp_rdata[0], 32'd0);
      chk("hs_req_ready", 32'(req_ready[0]), 32'd1);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
      chk("ignored_req_rdata", rd, 32'hDEAD_BEEF);

      // Reset during WAIT of a write
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_wen[0]   = 1'b1;
      req_addr[0]  = 32'h10;
      req_wdata[0] = 32'h5555_5555;
      req_wmask[0] = 4'hF;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstwait_req_ready", 32'(req_ready[0]), 32'd0);
      chk("rstwait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid[0] !== 1'b0) seen = 1'b1;
      end
      chk("rstwait_no_rsp", 32'(seen), 32'd0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat);
      chk("rstwait_old_word", rd, 32'hDEAD_BEEF);

      // Reset while a response is being held
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_wen[0]   = 1'b0;
      req_addr[0]  = 32'h20;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rstresp_valid_before", 32'(rsp_valid[0]), 32'd1);
      chk("rstresp_rdata_before", rsp_rdata[0], 32'h11BB_33DD);
      #2 rst_n = 1'b0;
      #1;
      chk("rstresp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rstresp_rdata", rsp_rdata[0], 32'd0);
      chk("rstresp_err", 32'(rsp_err[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // LATENCY=0 instance: back-to-back write then read at 0x0
      txn(1, 1'b1, 32'h0, 32'hA5A5_5A5A, 4'hF, rd, err, lat);
      chk("l0_write_latency", 32'(lat), 32'd1);
      chk("l0_write_err", 32'(err), 32'd0);
      txn(1, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, lat);
      chk("l0_read_latency", 32'(lat), 32'd1);
      chk("l0_read_rdata", rd, 32'hA5A5_5A5A);
      txn(1, 1'b0, 32'h400, 32'h0, 4'h0, rd, err, lat);
      chk("l0_oor_err", 32'(err), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
